// File: rtl/sensor_sample_tx.sv
// ============================================================================
// sensor_sample_tx
// ----------------------------------------------------------------------------
// Purpose:
//   Transmit side of the 8-bit parallel PMOD sensor link. A frame of samples
//   is buffered while IDLE, then replayed on jb0 at one sample every DIV clk
//   cycles. jb_stb pulses for one cycle whenever a new jb0 value appears.
//   The module acts as an on-board stimulus source for the capture chain.
//
// Ports:
//   clk      in   1       system clock, rising edge
//   reset    in   1       asynchronous, active-high reset
//   s_data   in   DATA_W  sample to load
//   s_valid  in   1       s_data valid
//   s_ready  out  1       buffer accepts s_data (IDLE and not full)
//   start    in   1       one-cycle pulse: begin playback
//   stop     in   1       one-cycle pulse: end playback after current period
//   jb0      out  DATA_W  transmitted sample, held between strobes
//   jb_stb   out  1       one-cycle pulse in the first cycle of a new jb0
//   busy     out  1       high while playing
//   done     out  1       one-cycle pulse when playback ends
//
// Configuration macro:
//   SENSOR_TX_LOOP_EN  when defined, playback wraps to the first sample and
//                      repeats with no gap until stop is seen.
// ============================================================================
module sensor_sample_tx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int DIV    = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] jb0,
    output logic              jb_stb,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [CW-1:0]     wr_cnt_q,  wr_cnt_d;
    logic [AW-1:0]     rd_idx_q,  rd_idx_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic              fin_q,     fin_d;     // frame ends at next period boundary
    logic [DATA_W-1:0] jb0_q,     jb0_d;
    logic              stb_q,     stb_d;

    logic              wr_en;
    logic              last_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    assign s_ready  = (state_q == IDLE) && (wr_cnt_q < CW'(DEPTH));
    assign busy     = (state_q == PLAY);
    assign done     = (state_q == DONE);
    assign jb0      = jb0_q;
    assign jb_stb   = stb_q;
    assign last_idx = ({1'b0, rd_idx_q} == (wr_cnt_q - CW'(1)));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_idx_d  = rd_idx_q;
        div_cnt_d = div_cnt_q;
        fin_d     = fin_q;
        jb0_d     = jb0_q;
        stb_d     = 1'b0;
        wr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + CW'(1);
                end
                // A write accepted in this same cycle counts toward the frame;
                // stop in the same cycle cancels the start.
                if (start && !stop && ((wr_cnt_q != '0) || wr_en)) begin
                    state_d   = PLAY;
                    rd_idx_d  = '0;
                    div_cnt_d = '0;
                    fin_d     = 1'b0;
                end
            end

            PLAY: begin
                div_cnt_d = (div_cnt_q == DW'(DIV - 1)) ? '0 : div_cnt_q + DW'(1);
                if (div_cnt_q == '0) begin
                    // Period boundary: either the frame is over or the next
                    // sample goes out on this edge.
                    if (fin_q || stop) begin
                        state_d = DONE;
                    end else begin
                        jb0_d = mem[rd_idx_q];
                        stb_d = 1'b1;
                        if (last_idx) begin
                            rd_idx_d = '0;
`ifdef SENSOR_TX_LOOP_EN
                            fin_d    = fin_q;
`else
                            fin_d    = 1'b1;
`endif
                        end else begin
                            rd_idx_d = rd_idx_q + AW'(1);
                        end
                    end
                end else if (stop) begin
                    fin_d = 1'b1;
                end
            end

            DONE: begin
                wr_cnt_d = '0;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            rd_idx_q  <= '0;
            div_cnt_q <= '0;
            fin_q     <= 1'b0;
            jb0_q     <= '0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_idx_q  <= rd_idx_d;
            div_cnt_q <= div_cnt_d;
            fin_q     <= fin_d;
            jb0_q     <= jb0_d;
            stb_q     <= stb_d;
        end
    end

    // NOTE: the frame buffer has no reset; wr_cnt bounds what is ever read,
    // and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[AW-1:0]] <= s_data;
        end
    end

endmodule

// File: tb/tb_sensor_sample_tx.sv
// ============================================================================
// tb_sensor_sample_tx
// ----------------------------------------------------------------------------
// Directed testbench for sensor_sample_tx (DATA_W=8, DEPTH=256, DIV=4).
// Edges are numbered by cyc (value after edge N is N). Inputs are driven 1
// time unit after a rising edge; outputs are recorded on the falling edge.
// ============================================================================
`timescale 1ns/1ps
module tb_sensor_sample_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       start;
    logic       stop;
    logic [7:0] jb0;
    logic       jb_stb;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         stb_cyc[$];
    logic [7:0] stb_val[$];
    int         done_cyc[$];
    int         busy_cnt;

    sensor_sample_tx #(.DATA_W(8), .DEPTH(256), .DIV(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .start   (start),
        .stop    (stop),
        .jb0     (jb0),
        .jb_stb  (jb_stb),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (jb_stb === 1'b1) begin
            stb_cyc.push_back(cyc);
            stb_val.push_back(jb0);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic clear_log();
        stb_cyc.delete();
        stb_val.delete();
        done_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step(1);
        s_valid = 1'b0;
    endtask

    // Returns the edge number at which start is sampled.
    task automatic pulse_start(output int k);
        start = 1'b1;
        k     = cyc + 1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_until(input int edge_n);
        while (cyc < edge_n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0; stop = 1'b0;
        step(2);
        total++;
        if ({jb0, jb_stb, busy, done, s_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got jb0=%h stb=%b busy=%b done=%b rdy=%b, want 00 0 0 0 1",
                     jb0, jb_stb, busy, done, s_ready);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid();
        int k;
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
        pulse_start(k);
        wait_until(k + 6);          // mid-period after the 2nd strobe
        clear_log();
        reset = 1'b1;
        #1;
        total++;
        if ({jb0, jb_stb, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_outputs: got jb0=%h stb=%b busy=%b done=%b, want 00 0 0 0",
                     jb0, jb_stb, busy, done);
        end
        step(1);
        reset = 1'b0;
        step(1);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready: got %b want 1", s_ready);
        end
        step(40);
        total++;
        if (done_cyc.size() != 0 || stb_cyc.size() != 0 || busy_cnt != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: got done=%0d stb=%0d busy=%0d want 0 0 0",
                     done_cyc.size(), stb_cyc.size(), busy_cnt);
        end
    endtask

    task automatic test_basic();
        int k;
        clear_log();
        for (int i = 0; i < 4; i++) push(8'(i));
        pulse_start(k);
        wait_until(k + 20);
        total++;
        if (stb_cyc.size() != 4) begin
            bad++;
            $display("FAIL basic_count: got %0d strobes want 4", stb_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (stb_cyc[i] != k + 1 + i * DIV || stb_val[i] !== 8'(i)) begin
                    bad++;
                    $display("FAIL basic_strobe%0d: got edge k+%0d val %h want edge k+%0d val %h",
                             i, stb_cyc[i] - k, stb_val[i], 1 + i * DIV, 8'(i));
                end
            end
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 17) begin
            bad++;
            $display("FAIL basic_done: got %0d pulses first at k+%0d want 1 at k+17",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - k : -1);
        end
        total++;
        if ({s_ready, busy, jb0} !== {1'b1, 1'b0, 8'h03}) begin
            bad++;
            $display("FAIL basic_after: got rdy=%b busy=%b jb0=%h want 1 0 03", s_ready, busy, jb0);
        end
    endtask

    task automatic test_full();
        int k;
        int errs;
        clear_log();
        for (int i = 0; i < 256; i++) push(8'(i) ^ 8'h5A);
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got %b want 0", s_ready);
        end
        push(8'hEE);                // must be dropped
        pulse_start(k);
        wait_until(k + 256 * DIV + 6);
        total++;
        if (stb_cyc.size() != 256) begin
            bad++;
            $display("FAIL full_count: got %0d strobes want 256", stb_cyc.size());
        end else begin
            errs = 0;
            for (int i = 0; i < 256; i++)
                if (stb_val[i] !== (8'(i) ^ 8'h5A)) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL full_values: got %0d wrong samples want 0", errs);
            end
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 1 + 256 * DIV) begin
            bad++;
            $display("FAIL full_done: got %0d pulses want 1 at k+%0d", done_cyc.size(), 1 + 256 * DIV);
        end
    endtask

    task automatic test_empty_start();
        int k;
        clear_log();
        pulse_start(k);
        step(12);
        total++;
        if (busy_cnt != 0 || stb_cyc.size() != 0 || done_cyc.size() != 0) begin
            bad++;
            $display("FAIL empty_start: got busy=%0d stb=%0d done=%0d want 0 0 0",
                     busy_cnt, stb_cyc.size(), done_cyc.size());
        end
        // Write and start in the same cycle: that sample forms the frame.
        clear_log();
        s_valid = 1'b1; s_data = 8'hA5; start = 1'b1;
        k = cyc + 1;
        step(1);
        s_valid = 1'b0; start = 1'b0;
        wait_until(k + 10);
        total++;
        if (stb_cyc.size() != 1 || stb_cyc[0] != k + 1 || stb_val[0] !== 8'hA5) begin
            bad++;
            $display("FAIL same_cycle_strobe: got %0d strobes val %h want 1 at k+1 val a5",
                     stb_cyc.size(), (stb_val.size() > 0) ? stb_val[0] : 8'hxx);
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 1 + DIV) begin
            bad++;
            $display("FAIL same_cycle_done: got %0d pulses want 1 at k+%0d", done_cyc.size(), 1 + DIV);
        end
    endtask

    task automatic test_stop();
        int k;
        int k2;
        clear_log();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        pulse_start(k);
        wait_until(k + 2);
        pulse_start(k2);            // ignored while playing
        wait_until(k + 6);          // cycle after the 2nd strobe
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_until(k + 40);
        total++;
        if (stb_cyc.size() != 2) begin
            bad++;
            $display("FAIL stop_count: got %0d strobes want 2", stb_cyc.size());
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 9) begin
            bad++;
            $display("FAIL stop_done: got %0d pulses first at k+%0d want 1 at k+9",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - k : -1);
        end
        total++;
        if (jb0 !== 8'h11) begin
            bad++;
            $display("FAIL stop_hold: got jb0=%h want 11", jb0);
        end
        // start and stop together in IDLE: stop wins, nothing plays.
        clear_log();
        push(8'h77);
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(8);
        total++;
        if (busy_cnt != 0 || stb_cyc.size() != 0) begin
            bad++;
            $display("FAIL start_stop_same: got busy=%0d stb=%0d want 0 0", busy_cnt, stb_cyc.size());
        end
        // Drain the pending sample so later tests start from an empty buffer.
        pulse_start(k);
        wait_until(k + DIV + 3);
        total++;
        if (stb_val.size() != 1 || stb_val[0] !== 8'h77) begin
            bad++;
            $display("FAIL start_stop_kept: got %0d strobes want 1 of 77", stb_val.size());
        end
    endtask

`ifdef SENSOR_TX_LOOP_EN
    task automatic test_loop();
        int k;
        logic [7:0] exp_v [5];
        exp_v[0] = 8'hA1; exp_v[1] = 8'hB2; exp_v[2] = 8'hC3; exp_v[3] = 8'hA1; exp_v[4] = 8'hB2;
        clear_log();
        push(8'hA1); push(8'hB2); push(8'hC3);
        pulse_start(k);
        wait_until(k + 18);         // inside the 5th period (B again)
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_until(k + 30);
        total++;
        if (stb_cyc.size() != 5) begin
            bad++;
            $display("FAIL loop_count: got %0d strobes want 5", stb_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (stb_cyc[i] != k + 1 + i * DIV || stb_val[i] !== exp_v[i]) begin
                    bad++;
                    $display("FAIL loop_strobe%0d: got k+%0d val %h want k+%0d val %h",
                             i, stb_cyc[i] - k, stb_val[i], 1 + i * DIV, exp_v[i]);
                end
            end
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 21) begin
            bad++;
            $display("FAIL loop_done: got %0d pulses want 1 at k+21", done_cyc.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid();
`ifdef SENSOR_TX_LOOP_EN
        test_loop();
`else
        test_basic();
        test_full();
        test_empty_start();
        test_stop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
